// File: rtl/result_serializer.sv
// -----------------------------------------------------------------------------
// result_serializer
//
// Captures a frame of NUM_UNITS lanes (plus one extra word) on a single load
// pulse and streams it out one lane per beat over a valid/ready handshake.
// When SEND_EXTRA is 1 the extra word follows the last lane as a final beat.
// A running checksum of transferred beats is kept for the current or most
// recent frame, and loads that arrive while a frame is in flight are dropped
// and flagged through a sticky overrun bit.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   load       : capture request for result_in / extra_in (honoured in IDLE)
//   result_in  : flattened lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   extra_in   : extra word sent after the lanes when SEND_EXTRA=1
//   out_valid  : out_data/out_index/out_last hold a beat
//   out_ready  : sink accepts the current beat
//   out_data   : current beat payload
//   out_index  : lane number of the beat (NUM_UNITS for the extra word)
//   out_last   : current beat is the final beat of the frame
//   busy       : a frame is in progress
//   checksum   : modulo-2^DATA_WIDTH sum of beats transferred in this frame
//   overrun    : sticky, set when a load is dropped because busy=1
// -----------------------------------------------------------------------------
module result_serializer #(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SEND_EXTRA = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0]   result_in,
    input  logic [DATA_WIDTH-1:0]             extra_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [$clog2(NUM_UNITS+1)-1:0]    out_index,
    output logic                              out_last,
    output logic                              busy,
    output logic [DATA_WIDTH-1:0]             checksum,
    output logic                              overrun
);

    localparam int IDX_W = $clog2(NUM_UNITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_UNITS - 1);
    localparam logic [IDX_W-1:0] EXTRA_IDX = IDX_W'(NUM_UNITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        EXTRA = 2'd2
    } state_t;

    state_t                 state_reg,    state_next;
    logic [IDX_W-1:0]       index_reg,    index_next;
    logic [DATA_WIDTH-1:0]  checksum_reg, checksum_next;
    logic                   overrun_reg,  overrun_next;

    logic [DATA_WIDTH-1:0]  lane_in  [NUM_UNITS];
    logic [DATA_WIDTH-1:0]  lane_reg [NUM_UNITS];
    logic [DATA_WIDTH-1:0]  extra_reg;
    logic [DATA_WIDTH-1:0]  lane_sel;

    logic                   capture;
    logic                   transfer;

    // Split the flattened input bus into lanes.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_UNITS; gi++) begin : g_lane_split
            assign lane_in[gi] = result_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Lane select as a compare-based mux so the index may be wider than
    // the lane count needs (it also has to encode the extra word).
    always_comb begin
        lane_sel = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (index_reg == IDX_W'(k)) begin
                lane_sel = lane_reg[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            index_reg    <= '0;
            checksum_reg <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            index_reg    <= index_next;
            checksum_reg <= checksum_next;
            overrun_reg  <= overrun_next;
        end
    end

    // ------------------------------------------------------------------
    // Capture registers: written only when a load is accepted in IDLE, so
    // later changes on result_in / extra_in cannot disturb a frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                lane_reg[k] <= '0;
            end
            extra_reg <= '0;
        end else if (capture) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                lane_reg[k] <= lane_in[k];
            end
            extra_reg <= extra_in;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode. Outputs depend only on registered
    // state, so out_valid never looks at out_ready and a presented beat
    // cannot change until it is transferred.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        checksum_next = checksum_reg;
        overrun_next  = overrun_reg;
        out_valid     = 1'b0;
        out_data      = '0;
        out_index     = '0;
        out_last      = 1'b0;
        busy          = 1'b0;
        capture       = 1'b0;
        transfer      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (load) begin
                    capture       = 1'b1;
                    state_next    = SEND;
                    index_next    = '0;
                    checksum_next = '0;
                end
            end

            SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = lane_sel;
                out_index = index_reg;
                out_last  = (index_reg == LAST_IDX) && (SEND_EXTRA == 0);
                transfer  = out_ready;
                // A load while busy is dropped, including on the final beat.
                if (load) begin
                    overrun_next = 1'b1;
                end
                if (transfer) begin
                    checksum_next = checksum_reg + lane_sel;
                    if (index_reg != LAST_IDX) begin
                        index_next = index_reg + 1'b1;
                    end else if (SEND_EXTRA != 0) begin
                        state_next = EXTRA;
                    end else begin
                        state_next = IDLE;
                        index_next = '0;
                    end
                end
            end

            EXTRA: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = extra_reg;
                out_index = EXTRA_IDX;
                out_last  = 1'b1;
                transfer  = out_ready;
                if (load) begin
                    overrun_next = 1'b1;
                end
                if (transfer) begin
                    checksum_next = checksum_reg + extra_reg;
                    state_next    = IDLE;
                    index_next    = '0;
                end
            end

            default: begin
                state_next = IDLE;
                index_next = '0;
            end
        endcase
    end

    assign checksum = checksum_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_result_serializer
//
// Two instances: dut (SEND_EXTRA=1) is driven by directed and random
// stimulus and checked by a scoreboard monitor; dut0 (SEND_EXTRA=0) gets a
// short directed frame. The reference model works at frame level: an
// accepted load expands into a queue of expected beats, a dropped load sets
// the expected overrun flag, and each transfer pops a beat and adds it into
// the expected checksum.
// -----------------------------------------------------------------------------
module tb_result_serializer;

    localparam int NU = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;

    // SEND_EXTRA=1 instance
    logic          load;
    logic [31:0]   result_in;
    logic [7:0]    extra_in;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic [2:0]    out_index;
    logic          out_last;
    logic          busy;
    logic [7:0]    checksum;
    logic          overrun;

    // SEND_EXTRA=0 instance
    logic          load0;
    logic [31:0]   result0;
    logic [7:0]    extra0;
    logic          v0;
    logic          ready0;
    logic [7:0]    d0;
    logic [2:0]    i0;
    logic          l0;
    logic          b0;
    logic [7:0]    c0;
    logic          o0;

    int n_checks = 0;
    int n_errors = 0;

    result_serializer #(.NUM_UNITS(NU), .DATA_WIDTH(DW), .SEND_EXTRA(1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .result_in(result_in),
        .extra_in(extra_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .busy(busy), .checksum(checksum), .overrun(overrun)
    );

    result_serializer #(.NUM_UNITS(NU), .DATA_WIDTH(DW), .SEND_EXTRA(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load0), .result_in(result0),
        .extra_in(extra0), .out_valid(v0), .out_ready(ready0),
        .out_data(d0), .out_index(i0), .out_last(l0),
        .busy(b0), .checksum(c0), .overrun(o0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model + monitor for dut
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] data;
        logic [2:0] idx;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] exp_cks = '0;
    logic       exp_ovr = 1'b0;

    always @(negedge clk) begin
        beat_t b;
        bit    in_frame;
        if (!rst_n) begin
            exp_q.delete();
            exp_cks = '0;
            exp_ovr = 1'b0;
            check("rst_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_checksum", checksum, 0);
            check("rst_overrun", overrun, 0);
        end else begin
            in_frame = (exp_q.size() != 0);
            check("valid", out_valid, in_frame);
            check("busy", busy, in_frame);
            check("checksum", checksum, exp_cks);
            check("overrun", overrun, exp_ovr);
            if (in_frame) begin
                b = exp_q[0];
                check("beat_data", out_data, b.data);
                check("beat_index", out_index, b.idx);
                check("beat_last", out_last, b.last);
                if (out_ready) begin
                    $display("beat idx=%0d data=%02h last=%0b", out_index, out_data, out_last);
                    exp_cks = exp_cks + b.data;
                    void'(exp_q.pop_front());
                end
            end else begin
                check("idle_last", out_last, 0);
            end
            if (load) begin
                if (in_frame) begin
                    exp_ovr = 1'b1;
                end else begin
                    exp_cks = '0;
                    for (int k = 0; k < NU; k++) begin
                        b.data = result_in[k*DW +: DW];
                        b.idx  = 3'(k);
                        b.last = 1'b0;
                        exp_q.push_back(b);
                    end
                    b.data = extra_in;
                    b.idx  = 3'(NU);
                    b.last = 1'b1;
                    exp_q.push_back(b);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_load(input logic [31:0] res, input logic [7:0] ext);
        @(posedge clk); #1;
        load      = 1'b1;
        result_in = res;
        extra_in  = ext;
        @(posedge clk); #1;
        load      = 1'b0;
    endtask

    // Waits for the frame to drain; toggle=1 alternates out_ready each cycle.
    task automatic wait_idle(input bit toggle);
        bit done = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                done = 1;
                break;
            end
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
        end
        check("wait_idle_timeout", done, 1);
        out_ready = 1'b1;
    endtask

    initial begin
        int  k;
        bit  found;
        rst_n = 1'b0; load = 1'b0; result_in = '0; extra_in = '0; out_ready = 1'b1;
        load0 = 1'b0; result0 = '0; extra0 = '0; ready0 = 1'b1;
        #1;
        check("async_rst_data", out_data, 0);
        check("async_rst_index", out_index, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic frame
        do_load(32'h44332211, 8'h55);
        wait_idle(0);
        check("basic_checksum", checksum, 8'hFF);

        // Backpressure
        out_ready = 1'b0;
        do_load(32'h44332211, 8'h55);
        wait_idle(1);
        check("bp_checksum", checksum, 8'hFF);

        // Overrun: second load two cycles after the first
        do_load(32'h44332211, 8'h55);
        @(posedge clk); #1;
        load = 1'b1; result_in = 32'hDEADBEEF; extra_in = 8'h99;
        @(posedge clk); #1;
        load = 1'b0;
        wait_idle(0);
        check("ovr_checksum", checksum, 8'hFF);
        check("ovr_flag", overrun, 1);
        repeat (3) @(posedge clk);
        #1;
        check("ovr_sticky", overrun, 1);

        // Reset mid-frame after index 1 is transferred
        do_load(32'h0A0B0C0D, 8'h0E);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid && out_ready && out_index == 3'd1) begin
                found = 1;
                break;
            end
        end
        check("rst_mid_found", found, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_checksum", checksum, 0);
        check("rst_mid_overrun", overrun, 0);
        check("rst_mid_index", out_index, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_after_valid", out_valid, 0);
        do_load(32'h40302010, 8'h50);
        check("restart_index", out_index, 0);
        check("restart_data", out_data, 8'h10);
        wait_idle(0);
        check("restart_checksum", checksum, 8'hF0);

        // Input change while a beat is stalled
        out_ready = 1'b0;
        do_load(32'h44332211, 8'h55);
        for (int i = 0; i < 4; i++) begin
            result_in = $urandom;
            extra_in  = 8'($urandom);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle(0);
        check("chg_checksum", checksum, 8'hFF);

        // SEND_EXTRA=0 instance
        @(posedge clk); #1;
        load0 = 1'b1; result0 = 32'h04030201; extra0 = 8'hEE;
        @(posedge clk); #1;
        load0 = 1'b0; result0 = 32'hFFFFFFFF; extra0 = 8'h77;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            @(negedge clk);
            if (v0) begin
                $display("beat0 idx=%0d data=%02h last=%0b", i0, d0, l0);
                check("f0_index", i0, k);
                check("f0_data", d0, k + 1);
                check("f0_last", l0, (k == 3));
                k++;
            end
        end
        check("f0_beats", k, 4);
        @(negedge clk);
        check("f0_no_extra_valid", v0, 0);
        check("f0_busy", b0, 0);
        check("f0_checksum", c0, 8'h0A);

        // Random traffic
        @(posedge clk); #1;
        for (int i = 0; i < 600; i++) begin
            load      = ($urandom_range(0, 5) == 0);
            result_in = $urandom;
            extra_in  = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        load = 1'b0;
        out_ready = 1'b1;
        wait_idle(0);
        repeat (2) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 4: number of lanes in a captured frame.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: width of each lane in bits.
REQ-003 SHALL have parameter SEND_EXTRA, default 1: when 1, the extra word is sent as the final beat of each frame.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port load, input, 1 bit: capture request for result_in and extra_in.
REQ-007 SHALL have port result_in, input, NUM_UNITS*DATA_WIDTH bits: flattened lanes, lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port extra_in, input, DATA_WIDTH bits: extra word.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a beat.
REQ-010 SHALL have port out_ready, input, 1 bit: the sink accepts the beat.
REQ-011 SHALL have port out_data, output, DATA_WIDTH bits: current beat.
REQ-012 SHALL have port out_index, output, $clog2(NUM_UNITS+1) bits: lane number of the beat; the extra word uses NUM_UNITS.
REQ-013 SHALL have port out_last, output, 1 bit: the current beat is the final beat of the frame.
REQ-014 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-015 SHALL have port checksum, output, DATA_WIDTH bits: running modulo-2^DATA_WIDTH sum of the beats transferred in the current or most recent frame.
REQ-016 SHALL have port overrun, output, 1 bit: sticky flag, set when a load is dropped.

Function
REQ-017 SHALL implement a state machine with states IDLE, SEND and EXTRA; busy = (state != IDLE).
REQ-018 IDLE with load=1 SHALL capture result_in and extra_in into internal registers, clear checksum to 0, set the lane index to 0 and enter SEND.
- out_valid rises on the following cycle (1-cycle latency).
REQ-019 SEND SHALL drive the following:
- out_valid=1.
- out_data = captured lane[index].
- out_index = index.
- out_last = (index==NUM_UNITS-1) && (SEND_EXTRA==0).
REQ-020 A transfer SHALL occur on any cycle with out_valid && out_ready.
- On a transfer, checksum becomes checksum + out_data, truncated to DATA_WIDTH bits.
REQ-021 A transfer in SEND SHALL behave as follows:
- index < NUM_UNITS-1: increment index.
- Otherwise with SEND_EXTRA=1: enter EXTRA.
- Otherwise with SEND_EXTRA=0: enter IDLE.
REQ-022 EXTRA SHALL drive out_valid=1, out_data = captured extra word, out_index = NUM_UNITS and out_last=1, and SHALL enter IDLE on a transfer.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL remain stable.
- Changes to result_in or extra_in after capture SHALL NOT affect the frame in progress.
REQ-024 out_valid SHALL NOT depend combinationally on out_ready.
- out_valid SHALL NOT drop without a transfer, except on reset.
REQ-025 load asserted while busy=1 SHALL be ignored and SHALL set overrun.
- This includes the cycle of the final transfer.
- The frame in progress is unaffected.
REQ-026 Back-to-back frames: after the final transfer busy=0 for at least one cycle, then a load in IDLE is accepted.
REQ-027 In IDLE: out_valid=0, out_last=0, and checksum holds its last value.

Reset
REQ-028 rst_n=0 SHALL immediately and asynchronously force the following, regardless of clk:
- state=IDLE, index=0.
- out_valid=0, out_last=0, busy=0.
- out_data=0, out_index=0.
- checksum=0, overrun=0.
- Captured registers = 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame; no further beats of that frame are emitted after release.
REQ-030 The first load SHALL be accepted no earlier than the first rising clk edge with rst_n=1.

Verification (NUM_UNITS=4, DATA_WIDTH=8, SEND_EXTRA=1 unless stated)
REQ-031 Basic frame: load with result_in=32'h44332211 and extra_in=8'h55, out_ready=1 -> beats (index, data) are (0,11) (1,22) (2,33) (3,44) (4,55) on consecutive cycles, out_last only on index 4, final checksum=8'hFF.
REQ-032 Backpressure: same frame, with out_ready toggling 0/1 every cycle -> each beat is held stable while stalled, the same 5 beats appear in order, and checksum=8'hFF.
REQ-033 SEND_EXTRA=0: result_in=32'h04030201 -> 4 beats, out_last on index 3, checksum=8'h0A, and the EXTRA state is never entered.
REQ-034 Overrun: a second load 2 cycles after the first -> the frame carries only the first capture's data and overrun=1 stays set until reset.
REQ-035 Reset mid-frame: rst_n low after the beat at index 1 is transferred -> out_valid=0, busy=0, checksum=0 and overrun=0 at once; after release and a new load, the frame restarts at index 0.
REQ-036 Input change: result_in changes while a stalled beat is presented -> the remaining beats still match the captured values.
